async_fifo_reader: RTL and testbench

Read-side consumer for `asynchronous_fifo`, living entirely in the read clock domain. It issues `r_enable` against the FIFO's `empty` flag and absorbs the FIFO's one-cycle read latency. It re-presents the data as a valid/ready stream with burst framing (`m_last`) and a running word count. Downstream logic can then stall freely without losing in-flight words.

---
 rtl/async_fifo_pkg.sv | 16 +
 rtl/reader_skid_buf.sv | 58 +++++
 rtl/async_fifo_reader.sv | 73 +++++++
 tb/tb_async_fifo_reader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared constants and types for the asynchronous FIFO and its read-side consumer.
// BITSIZE and MEMSIZE are the FIFO defaults; the reader's output buffer depth is fixed here.
package async_fifo_pkg;

  localparam int BITSIZE   = 8;
  localparam int MEMSIZE   = 16;
  localparam int BUF_DEPTH = 3;

  typedef logic [1:0] occ_t;

  // Wraps at BUF_DEPTH, which is not a power of two.
  function automatic occ_t ptr_inc(input occ_t p);
    return (p == occ_t'(BUF_DEPTH - 1)) ? '0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/reader_skid_buf.sv
// Three-entry circular buffer between the FIFO read port and the downstream stream.
// Callers never push when full or pop when empty.
module reader_skid_buf #(
  parameter int WIDTH = async_fifo_pkg::BITSIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head,
  output async_fifo_pkg::occ_t occ
);
  import async_fifo_pkg::*;

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [BUF_DEPTH];
  occ_t wr_ptr_q, wr_ptr_d;
  occ_t rd_ptr_q, rd_ptr_d;
  occ_t occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign occ  = occ_q;

endmodule

// File: rtl/async_fifo_reader.sv
// Read-side consumer for the asynchronous FIFO: issues reads against empty, absorbs the
// one-cycle read latency and re-presents data as a valid/ready stream with burst framing.
module async_fifo_reader #(
  parameter int BITSIZE    = async_fifo_pkg::BITSIZE,
  parameter int BURSTLEN   = 4,
  parameter int COUNTWIDTH = 16
) (
  input  logic                  r_clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [BITSIZE-1:0]    rdata,
  output logic                  r_enable,
  output logic [BITSIZE-1:0]    m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [COUNTWIDTH-1:0] word_count
);
  import async_fifo_pkg::*;

  localparam logic [7:0] LAST_BEAT = 8'(BURSTLEN - 1);

  logic                  inflight_q, inflight_d;
  logic [7:0]            beat_q, beat_d;
  logic [COUNTWIDTH-1:0] word_count_q, word_count_d;
  occ_t                  occ;
  logic [2:0]            pending;
  logic                  pop;

  // Issue only from registered state so m_ready never reaches r_enable combinationally.
  assign pending  = {1'b0, occ} + {2'b00, inflight_q};
  assign r_enable = !empty && !reset && (pending < 3'(BUF_DEPTH));

  assign m_valid    = (occ != '0);
  assign pop        = m_valid && m_ready;
  assign m_last     = m_valid && (beat_q == LAST_BEAT);
  assign word_count = word_count_q;

  always_comb begin
    inflight_d   = r_enable;
    beat_d       = beat_q;
    word_count_d = word_count_q;
    if (pop) begin
      beat_d       = (beat_q == LAST_BEAT) ? 8'd0 : beat_q + 8'd1;
      word_count_d = word_count_q + COUNTWIDTH'(1);
    end
  end

  always_ff @(posedge r_clk) begin
    if (reset) begin
      inflight_q   <= 1'b0;
      beat_q       <= '0;
      word_count_q <= '0;
    end else begin
      inflight_q   <= inflight_d;
      beat_q       <= beat_d;
      word_count_q <= word_count_d;
    end
  end

  reader_skid_buf #(
    .WIDTH(BITSIZE)
  ) u_skid_buf (
    .clk      (r_clk),
    .reset    (reset),
    .push     (inflight_q),
    .push_data(rdata),
    .pop      (pop),
    .head     (m_data),
    .occ      (occ)
  );

endmodule

// File: tb/tb_async_fifo_reader.sv
// Directed bench for async_fifo_reader: a behavioural FIFO read port feeds the default
// instance, a counting source feeds a small-counter instance for wrap and burst-of-one checks.
module tb_async_fifo_reader;

  logic       r_clk = 1'b0;
  logic       reset;
  logic       empty;
  logic [7:0] rdata = '0;
  logic       r_enable;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic [15:0] word_count;

  logic       reset2;
  logic       empty2;
  logic [7:0] rdata2 = '0;
  logic       r_enable2;
  logic [7:0] m_data2;
  logic       m_valid2;
  logic       m_ready2;
  logic       m_last2;
  logic [3:0] word_count2;

  int passed = 0;
  int total  = 0;

  always #5 r_clk = ~r_clk;

  async_fifo_reader dut (
    .r_clk     (r_clk),
    .reset     (reset),
    .empty     (empty),
    .rdata     (rdata),
    .r_enable  (r_enable),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .word_count(word_count)
  );

  async_fifo_reader #(
    .BITSIZE(8), .BURSTLEN(1), .COUNTWIDTH(4)
  ) dut_wrap (
    .r_clk     (r_clk),
    .reset     (reset2),
    .empty     (empty2),
    .rdata     (rdata2),
    .r_enable  (r_enable2),
    .m_data    (m_data2),
    .m_valid   (m_valid2),
    .m_ready   (m_ready2),
    .m_last    (m_last2),
    .word_count(word_count2)
  );

  // FIFO read-port model: one-cycle read latency, bench writes fifo_wr, model owns fifo_rd.
  logic [7:0] fifo_mem [256];
  int fifo_wr = 0;
  int fifo_rd = 0;
  logic empty_force = 1'b0;
  assign empty = (fifo_rd == fifo_wr) || empty_force;

  always @(posedge r_clk) begin
    if (r_enable && !empty) begin
      rdata   <= fifo_mem[fifo_rd % 256];
      fifo_rd <= fifo_rd + 1;
    end
  end

  int src_limit2  = 0;
  int src_issued2 = 0;
  assign empty2 = (src_issued2 >= src_limit2);

  always @(posedge r_clk) begin
    if (r_enable2 && !empty2) begin
      rdata2      <= 8'(src_issued2 + 1);
      src_issued2 <= src_issued2 + 1;
    end
  end

  task automatic preload(input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) fifo_mem[(fifo_wr + k) % 256] = first + 8'(k);
    fifo_wr = fifo_wr + n;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge r_clk);
      total++;
      if (r_enable !== 1'b0 || m_valid !== 1'b0 || word_count !== 16'd0) begin
        $display("FAIL reset cyc%0d: r_enable=%b m_valid=%b word_count=%0d, want 0/0/0",
                 i, r_enable, m_valid, word_count);
      end else passed++;
    end
    total++;
    if (m_data !== 8'h00 || m_last !== 1'b0) begin
      $display("FAIL reset_outputs: m_data=%h m_last=%b, want 00/0", m_data, m_last);
    end else passed++;
    @(posedge r_clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_stream();
    int   first_en  = -1;
    int   first_val = -1;
    int   n         = 0;
    logic exp_last;
    for (int i = 0; i < 20; i++) begin
      @(negedge r_clk);
      if (r_enable && first_en < 0) first_en = i;
      if (m_valid) begin
        if (first_val < 0) first_val = i;
        exp_last = (n % 4 == 3);
        total++;
        if (m_data !== 8'(n + 1) || m_last !== exp_last || i != first_val + n) begin
          $display("FAIL stream word%0d: data=%h last=%b cyc=%0d, want data=%h last=%b cyc=%0d",
                   n, m_data, m_last, i, 8'(n + 1), exp_last, first_val + n);
        end else passed++;
        n++;
      end
    end
    total++;
    if (first_en < 0 || first_val != first_en + 2) begin
      $display("FAIL stream_latency: first valid cyc %0d, first r_enable cyc %0d, want +2",
               first_val, first_en);
    end else passed++;
    total++;
    if (n != 8 || word_count !== 16'd8) begin
      $display("FAIL stream_count: words=%0d word_count=%0d, want 8/8", n, word_count);
    end else passed++;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_next = 8'h10;
    int         en_in_stall = 0;
    preload(8'h10, 16);
    for (int i = 0; i < 50; i++) begin
      @(posedge r_clk);
      #1 m_ready = !(i >= 6 && i < 16);
      @(negedge r_clk);
      if (!m_ready) begin
        if (r_enable) en_in_stall++;
        total++;
        if (m_valid !== 1'b1 || m_data !== exp_next) begin
          $display("FAIL bp_hold cyc%0d: valid=%b data=%h, want 1/%h", i, m_valid, m_data, exp_next);
        end else passed++;
        if (i >= 7) begin
          total++;
          if (r_enable !== 1'b0) begin
            $display("FAIL bp_full cyc%0d: r_enable=%b, want 0", i, r_enable);
          end else passed++;
        end
      end else if (m_valid) begin
        total++;
        if (m_data !== exp_next || m_last !== (exp_next[1:0] == 2'b11)) begin
          $display("FAIL bp_word: data=%h last=%b, want %h/%b",
                   m_data, m_last, exp_next, (exp_next[1:0] == 2'b11));
        end else passed++;
        exp_next = exp_next + 8'd1;
      end
    end
    total++;
    if (en_in_stall != 1) begin
      $display("FAIL bp_issue: r_enable cycles during stall=%0d, want 1", en_in_stall);
    end else passed++;
    total++;
    if (exp_next !== 8'h20 || word_count !== 16'd24) begin
      $display("FAIL bp_count: next=%h word_count=%0d, want 20/24", exp_next, word_count);
    end else passed++;
  endtask

  task automatic test_empty_toggle();
    logic [7:0] exp_next = 8'hA0;
    empty_force = 1'b1;
    preload(8'hA0, 8);
    for (int i = 0; i < 40; i++) begin
      @(posedge r_clk);
      #1 empty_force = (i % 2 == 0);
      @(negedge r_clk);
      total++;
      if (r_enable !== !empty) begin
        $display("FAIL toggle_issue cyc%0d: r_enable=%b empty=%b, want r_enable=%b",
                 i, r_enable, empty, !empty);
      end else passed++;
      if (m_valid) begin
        total++;
        if (m_data !== exp_next || m_last !== (exp_next[1:0] == 2'b11)) begin
          $display("FAIL toggle_word: data=%h last=%b, want %h/%b",
                   m_data, m_last, exp_next, (exp_next[1:0] == 2'b11));
        end else passed++;
        exp_next = exp_next + 8'd1;
      end
    end
    empty_force = 1'b0;
    total++;
    if (exp_next !== 8'hA8 || word_count !== 16'd32) begin
      $display("FAIL toggle_count: next=%h word_count=%0d, want A8/32", exp_next, word_count);
    end else passed++;
  endtask

  task automatic test_midstream_reset();
    preload(8'h55, 1);
    #1;
    total++;
    if (r_enable !== 1'b1) begin
      $display("FAIL mrst_issue: r_enable=%b, want 1", r_enable);
    end else passed++;
    @(posedge r_clk);
    #1 reset = 1'b1;
    @(negedge r_clk);
    total++;
    if (r_enable !== 1'b0) begin
      $display("FAIL mrst_gate: r_enable=%b during reset, want 0", r_enable);
    end else passed++;
    @(posedge r_clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge r_clk);
      total++;
      if (m_valid !== 1'b0 || m_data === 8'h55 || word_count !== 16'd0) begin
        $display("FAIL mrst_discard cyc%0d: valid=%b data=%h word_count=%0d, want 0/not55/0",
                 i, m_valid, m_data, word_count);
      end else passed++;
    end
  endtask

  task automatic test_counter_wrap();
    int hs = 0;
    @(posedge r_clk);
    #1 reset2 = 1'b0;
    src_limit2 = 17;
    for (int i = 0; i < 40; i++) begin
      @(negedge r_clk);
      if (m_valid2) begin
        total++;
        if (m_last2 !== 1'b1 || m_data2 !== 8'(hs + 1) || word_count2 !== 4'(hs)) begin
          $display("FAIL wrap_word%0d: last=%b data=%h count=%0d, want 1/%h/%0d",
                   hs, m_last2, m_data2, word_count2, 8'(hs + 1), 4'(hs));
        end else passed++;
        hs++;
      end
    end
    total++;
    if (hs != 17 || word_count2 !== 4'd1) begin
      $display("FAIL wrap_final: words=%0d word_count=%0d, want 17/1", hs, word_count2);
    end else passed++;
  endtask

  initial begin
    reset    = 1'b1;
    reset2   = 1'b1;
    m_ready  = 1'b1;
    m_ready2 = 1'b1;
    preload(8'h01, 8);
    test_reset();
    test_stream();
    test_backpressure();
    test_empty_toggle();
    test_midstream_reset();
    test_counter_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
